// File: rtl/logic_serial_unit.sv
// logic_serial_unit: handshaked multi-cycle bitwise logic unit, SLICE bits per cycle.
// Revision 1.0 - initial release
`default_nettype none

module logic_serial_unit #(
  parameter int XLEN  = 64,
  parameter int SLICE = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            illegal_o,
  output logic            busy_o
);

  localparam int NSLICE = XLEN / SLICE;
  localparam int CW     = (NSLICE > 2) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NSLICE - 1);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_ANDN = 3'b011;
  localparam logic [2:0] OP_ORN  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            illegal_q, illegal_d;
  logic [SLICE-1:0] w_slice;

  // Illegal opcodes fall through to zero, so an illegal op writes all-zero slices.
  function automatic logic [SLICE-1:0] slice_f(input logic [2:0] op,
                                               input logic [SLICE-1:0] a,
                                               input logic [SLICE-1:0] b);
    logic [SLICE-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_ANDN: r = a & ~b;
      OP_ORN:  r = a | ~b;
      OP_XNOR: r = ~(a ^ b);
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    w_slice   = slice_f(op_q, a_q[int'(cnt_q)*SLICE +: SLICE], b_q[int'(cnt_q)*SLICE +: SLICE]);

    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          a_d       = a_i;
          b_d       = b_i;
          op_d      = op_i;
          illegal_d = op_i[2] & op_i[1];
          result_d  = '0;
          cnt_d     = '0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        result_d[int'(cnt_q)*SLICE +: SLICE] = w_slice;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready_o  = (state_q == S_IDLE);
  assign out_valid_o = (state_q == S_DONE);
  assign busy_o      = (state_q != S_IDLE);
  assign result_o    = result_q;
  assign illegal_o   = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_logic_serial_unit.sv
// tb_logic_serial_unit: directed self-checking bench for logic_serial_unit.
// Revision 1.0 - initial release
`default_nettype none

module tb_logic_serial_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [2:0]  op_i;
  logic [63:0] a_i;
  logic [63:0] b_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [63:0] result_o;
  logic        illegal_o;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic_serial_unit #(.XLEN(64), .SLICE(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .op_i       (op_i),
    .a_i        (a_i),
    .b_i        (b_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .result_o   (result_o),
    .illegal_o  (illegal_o),
    .busy_o     (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Accepts one operation with out_ready already high and checks latency, result and drain.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp_res, input logic exp_ill);
    int lat;
    check({tag, "_in_ready"}, 64'(in_ready_o), 64'd1);
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    op_i = op; a_i = a; b_i = b;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    lat = 0;
    while (lat < 20 && !out_valid_o) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd8);
    check({tag, "_res"}, result_o, exp_res);
    check({tag, "_ill"}, 64'(illegal_o), 64'(exp_ill));
    @(posedge clk); #1;
    check({tag, "_ov_drop"}, 64'(out_valid_o), 64'd0);
    check({tag, "_rdy_back"}, 64'(in_ready_o), 64'd1);
  endtask

  localparam logic [63:0] VA = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] VB = 64'hFFFF_0000_FFFF_0000;

  initial begin
    logic [63:0] exp_tab [6];
    logic [63:0] ea, eb, exp_r, held_r;
    logic        seen;
    int          lat;

    exp_tab[0] = 64'h0123_0000_89AB_0000;
    exp_tab[1] = 64'hFFFF_4567_FFFF_CDEF;
    exp_tab[2] = 64'hFEDC_4567_7654_CDEF;
    exp_tab[3] = 64'h0000_4567_0000_CDEF;
    exp_tab[4] = 64'h0123_FFFF_89AB_FFFF;
    exp_tab[5] = 64'h0123_BA98_89AB_3210;

    rst_n = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    op_i = 3'd0; a_i = '0; b_i = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(in_ready_o), 64'd1);
    check("rst_out_valid", 64'(out_valid_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_result", result_o, 64'd0);
    check("rst_illegal", 64'(illegal_o), 64'd0);

    run_op("and_drain", 3'b000, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
           64'hF000_F000_F000_F000, 1'b0);

    for (int k = 0; k < 6; k++)
      run_op($sformatf("op%0d", k), 3'(k), VA, VB, exp_tab[k], 1'b0);

    // Low-byte sweep against the plain bitwise model for AND/OR/XOR.
    for (int i = 0; i < 256; i += 17) begin
      for (int j = 0; j < 256; j += 17) begin
        ea = {56'h5A5A_0F0F_3C3C_96, 8'(i)};
        eb = {56'hC3C3_F00F_A5A5_69, 8'(j)};
        run_op("sw_and", 3'b000, ea, eb, ea & eb, 1'b0);
        run_op("sw_or",  3'b001, ea, eb, ea | eb, 1'b0);
        run_op("sw_xor", 3'b010, ea, eb, ea ^ eb, 1'b0);
      end
    end

    // Backpressure: hold output for 5 cycles while a fresh request is offered.
    out_ready_i = 1'b0;
    in_valid_i = 1'b1; op_i = 3'b010; a_i = VA; b_i = VB;
    @(posedge clk); #1;
    a_i = 64'hDEAD_BEEF_DEAD_BEEF; op_i = 3'b000;
    lat = 0;
    while (lat < 20 && !out_valid_o) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_lat", 64'(lat), 64'd8);
    held_r = exp_tab[2];
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_ov", 64'(out_valid_o), 64'd1);
      check("bp_res", result_o, held_r);
      check("bp_ill", 64'(illegal_o), 64'd0);
      check("bp_in_ready", 64'(in_ready_o), 64'd0);
    end
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    check("bp_ov_drop", 64'(out_valid_o), 64'd0);
    check("bp_in_ready_back", 64'(in_ready_o), 64'd1);
    check("bp_no_same_cycle_accept", 64'(busy_o), 64'd0);
    in_valid_i = 1'b0;
    check("bp_res_held", result_o, held_r);

    // Operands change every cycle after accept; only the captured values matter.
    ea = 64'h1357_9BDF_2468_ACE0; eb = 64'h0F0F_F0F0_3333_CCCC;
    in_valid_i = 1'b1; op_i = 3'b101; a_i = ea; b_i = eb;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    lat = 0;
    while (lat < 20 && !out_valid_o) begin
      a_i = {$urandom, $urandom}; b_i = {$urandom, $urandom}; op_i = 3'($urandom_range(0, 7));
      @(posedge clk); #1;
      lat++;
    end
    check("chg_lat", 64'(lat), 64'd8);
    check("chg_res", result_o, 64'hE3A7_94D0_E8A4_9FD3);
    @(posedge clk); #1;

    run_op("ill7", 3'b111, VA, VB, 64'd0, 1'b1);
    run_op("ill6", 3'b110, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
    run_op("ill_clear", 3'b001, 64'd0, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 1'b0);

    // Reset asserted in the 4th RUN cycle discards the operation.
    in_valid_i = 1'b1; op_i = 3'b000; a_i = VA; b_i = VB;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy_o), 64'd0);
    check("mid_rst_ov", 64'(out_valid_o), 64'd0);
    check("mid_rst_res", result_o, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (out_valid_o) seen = 1'b1;
    end
    check("mid_rst_no_ov", 64'(seen), 64'd0);
    run_op("post_rst_and", 3'b000, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
           64'hF000_F000_F000_F000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
